// File: rtl/tpiu_frame_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : tpiu_frame_fifo_if
// Purpose  : Frame output handshake between the TPIU front end and the
//            packet processor. The producer presents the FIFO head frame with
//            a valid flag; the consumer pops it with ready.
// Signals  : frameValid - head frame present (producer -> consumer)
//            frameReady - consumer accepts the head frame (consumer -> producer)
//            frame      - 128-bit head frame, first halfword in [127:112]
// Modports : master (producer side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface tpiu_frame_fifo_if;
  logic         frameValid;
  logic         frameReady;
  logic [127:0] frame;

  modport master (
    output frameValid,
    output frame,
    input  frameReady
  );

  modport slave (
    input  frameValid,
    input  frame,
    output frameReady
  );
endinterface
`default_nettype wire

// File: rtl/tpiu_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tpiu_frame_fifo
// Purpose  : TPIU trace-port front end. Samples 1/2/4/8-bit DDR trace data,
//            acquires and tracks full-sync alignment, assembles 16-bit
//            halfwords into 128-bit frames and buffers completed frames in a
//            first-word-fall-through FIFO with drop accounting.
// Ports    : traceClkin - trace clock, all logic on the rising edge
//            rstn       - asynchronous active-low reset
//            traceDina  - rising-edge data (low bits of each beat)
//            traceDinb  - falling-edge data (high bits of each beat)
//            width      - bus width code 0..3 = 1/2/4/8 pins (clamped)
//            o_frm      - frame handshake (frameValid/frameReady/frame)
//            synced     - sync lifetime counter non-zero
//            lostFrames - saturating count of frames dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module tpiu_frame_fifo #(
  parameter int MAXBUSWIDTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_BITS   = 27
) (
  input  logic                   traceClkin,
  input  logic                   rstn,
  input  logic [MAXBUSWIDTH-1:0] traceDina,
  input  logic [MAXBUSWIDTH-1:0] traceDinb,
  input  logic [1:0]             width,
  tpiu_frame_fifo_if.master      o_frm,
  output logic                   synced,
  output logic [7:0]             lostFrames
);

  localparam logic [1:0]  c_MAXCODE = (MAXBUSWIDTH >= 8) ? 2'd3 :
                                      (MAXBUSWIDTH >= 4) ? 2'd2 :
                                      (MAXBUSWIDTH >= 2) ? 2'd1 : 2'd0;
  localparam int          c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] c_SYNC    = 32'h7FFF_FFFF;
  localparam logic [15:0] c_PASS    = 16'h7FFF;

  // Alignment / assembly state
  logic [31:0]          r_construct;
  logic [1:0]           r_width;
  logic [2:0]           r_phase;
  logic [2:0]           r_idx;
  logic [SYNC_BITS-1:0] r_sync;
  logic [111:0]         r_asm;      // slots 0..6; slot 7 goes straight to the FIFO

  // FIFO state
  logic [127:0]         r_mem [FIFO_DEPTH];
  logic [c_AW:0]        r_wr;
  logic [c_AW:0]        r_rd;
  logic [7:0]           r_lost;

  logic [7:0]   w_dina8;
  logic [7:0]   w_dinb8;
  logic [1:0]   w_code;
  logic [31:0]  w_shift;
  logic [2:0]   w_reload;
  logic         w_wchg;
  logic         w_sync_hit;
  logic [15:0]  w_h;
  logic [15:0]  w_hsw;
  logic         w_take;
  logic         w_push_req;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  logic [127:0] w_frame;

  // Zero-extend so the width mux below can always name eight pin bits;
  // bits above MAXBUSWIDTH are unreachable once the code is clamped.
  assign w_dina8 = 8'(traceDina);
  assign w_dinb8 = 8'(traceDinb);

  // New beat enters at the top; older bits move toward bit 0, so the
  // oldest bit of a halfword ends up as its LSB.
  always_comb begin
    w_code = (width > c_MAXCODE) ? c_MAXCODE : width;
    case (w_code)
      2'd0: begin
        w_shift  = {w_dinb8[0],   w_dina8[0],   r_construct[31:2]};
        w_reload = 3'd7;
      end
      2'd1: begin
        w_shift  = {w_dinb8[1:0], w_dina8[1:0], r_construct[31:4]};
        w_reload = 3'd3;
      end
      2'd2: begin
        w_shift  = {w_dinb8[3:0], w_dina8[3:0], r_construct[31:8]};
        w_reload = 3'd1;
      end
      default: begin
        w_shift  = {w_dinb8, w_dina8, r_construct[31:16]};
        w_reload = 3'd0;
      end
    endcase
  end

  assign w_wchg     = (width != r_width);
  assign w_sync_hit = (r_construct == c_SYNC);
  assign w_h        = r_construct[31:16];
  assign w_hsw      = {w_h[7:0], w_h[15:8]};
  // A halfword is taken only on a phase-0 edge that is neither a sync edge
  // nor a width-change edge, and only if it is not a pass.
  assign w_take     = !w_wchg && !w_sync_hit && (r_phase == 3'd0) && (w_h != c_PASS);
  // Frames completed without alignment are meaningless and vanish silently.
  assign w_push_req = w_take && (r_idx == 3'd7) && (r_sync != '0);
  assign w_frame    = {r_asm, w_hsw};

  always_ff @(posedge traceClkin or negedge rstn) begin
    if (!rstn) begin
      r_construct <= '0;
      r_width     <= '0;
      r_phase     <= '0;
      r_idx       <= '0;
      r_sync      <= '0;
      r_asm       <= '0;
    end else begin
      r_width <= width;
      if (w_wchg) begin
        r_construct <= '0;
        r_idx       <= '0;
        r_phase     <= '0;
        r_sync      <= '0;
      end else begin
        r_construct <= w_shift;
        if (w_sync_hit) begin
          r_phase <= w_reload;
          r_idx   <= '0;
          r_sync  <= '1;
        end else begin
          if (r_sync != '0) begin
            r_sync <= r_sync - SYNC_BITS'(1);
          end
          if (r_phase == 3'd0) begin
            r_phase <= w_reload;
          end else begin
            r_phase <= r_phase - 3'd1;
          end
          if (w_take) begin
            // Slot i sits at [111-16i -: 16]; slot 7 bypasses the register.
            if (r_idx != 3'd7) begin
              r_asm[{3'd6 - r_idx, 4'd0} +: 16] <= w_hsw;
            end
            r_idx <= r_idx + 3'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FIFO: extra pointer bit distinguishes full from empty.
  // ---------------------------------------------------------------------
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[c_AW] != r_rd[c_AW]) &&
                   (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign w_pop   = !w_empty && o_frm.frameReady;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge traceClkin or negedge rstn) begin
    if (!rstn) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_lost <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + (c_AW+1)'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + (c_AW+1)'(1);
      end
      if (w_drop && (r_lost != 8'hFF)) begin
        r_lost <= r_lost + 8'd1;
      end
    end
  end

  always_ff @(posedge traceClkin) begin
    if (w_push) begin
      r_mem[r_wr[c_AW-1:0]] <= w_frame;
    end
  end

  assign o_frm.frameValid = !w_empty;
  assign o_frm.frame      = w_empty ? '0 : r_mem[r_rd[c_AW-1:0]];
  assign synced           = (r_sync != '0);
  assign lostFrames       = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_tpiu_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpiu_frame_fifo
// Purpose  : Self-checking bench for tpiu_frame_fifo. Main instance uses the
//            default parameters; a second instance with SYNC_BITS=4 shares the
//            trace inputs to exercise sync expiry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpiu_frame_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] dina;
  logic [7:0] dinb;
  logic [1:0] wcode;
  logic       ready;
  logic       synced;
  logic       synced_s;
  logic [7:0] lost;
  logic [7:0] lost_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] q [$];

  tpiu_frame_fifo_if u_if ();
  tpiu_frame_fifo_if u_if_s ();

  assign u_if.frameReady   = ready;
  assign u_if_s.frameReady = 1'b0;

  tpiu_frame_fifo #(.MAXBUSWIDTH(8), .FIFO_DEPTH(4), .SYNC_BITS(27)) u_dut (
    .traceClkin (clk),
    .rstn       (rstn),
    .traceDina  (dina),
    .traceDinb  (dinb),
    .width      (wcode),
    .o_frm      (u_if.master),
    .synced     (synced),
    .lostFrames (lost)
  );

  tpiu_frame_fifo #(.MAXBUSWIDTH(8), .FIFO_DEPTH(4), .SYNC_BITS(4)) u_dut_s (
    .traceClkin (clk),
    .rstn       (rstn),
    .traceDina  (dina),
    .traceDinb  (dinb),
    .width      (wcode),
    .o_frm      (u_if_s.master),
    .synced     (synced_s),
    .lostFrames (lost_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every frame that is popped on the following rising edge.
  always @(negedge clk) begin
    if (rstn && u_if.frameValid && u_if.frameReady) q.push_back(u_if.frame);
  end

  typedef struct {
    logic [1:0]   wc;
    logic [127:0] hws;    // halfword i at [127-16i -: 16]
    logic [7:0]   pmask;  // bit i: send a pass before halfword i
    logic [127:0] exp;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    dina = a;
    dinb = b;
    @(posedge clk);
    #1;
  endtask

  // Serialise v LSB-first at the current width: each beat carries 2w bits,
  // low w bits on traceDina, next w bits on traceDinb.
  task automatic send_bits(input logic [31:0] v, input int nbits);
    int          w;
    logic [31:0] c;
    logic [7:0]  m;
    w = 1 << wcode;
    m = 8'((16'd1 << w) - 16'd1);
    for (int k = 0; k < nbits / (2 * w); k++) begin
      c = v >> (2 * w * k);
      beat(c[7:0] & m, 8'(c >> w) & m);
    end
  endtask

  task automatic send_hw(input logic [15:0] h);
    send_bits({16'h0000, h}, 16);
  endtask

  task automatic send_sync();
    send_bits(32'h7FFF_FFFF, 32);
  endtask

  task automatic pass(input int n);
    for (int i = 0; i < n; i++) send_hw(16'h7FFF);
  endtask

  task automatic set_width(input logic [1:0] c);
    wcode = c;
    for (int i = 0; i < 3; i++) beat(8'h00, 8'h00);
  endtask

  task automatic send_frame(input logic [127:0] hws, input logic [7:0] pmask);
    logic [15:0] h;
    for (int i = 0; i < 8; i++) begin
      if (pmask[i]) pass(1);
      h = hws[127 - 16 * i -: 16];
      send_hw(h);
    end
  endtask

  function automatic logic [15:0] hw_a(input int f, input int k);
    return 16'((f + 1) * 16'h1000 + (k + 1) * 16'h0011);
  endfunction

  function automatic logic [127:0] mkframe(input int f);
    logic [127:0] r;
    logic [15:0]  h;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      h = hw_a(f, k);
      r = {r[111:0], h[7:0], h[15:8]};
    end
    return r;
  endfunction

  task automatic send_frame_a(input int f);
    for (int k = 0; k < 8; k++) send_hw(hw_a(f, k));
  endtask

  initial begin
    vt[0] = '{wc: 2'd2, hws: 128'h1122_2233_3344_4455_5566_6677_7788_8899, pmask: 8'h00,
              exp: 128'h2211_3322_4433_5544_6655_7766_8877_9988};
    vt[1] = '{wc: 2'd0, hws: 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, pmask: 8'hA5,
              exp: 128'h0201_0403_0605_0807_0A09_0C0B_0E0D_100F};
    vt[2] = '{wc: 2'd1, hws: 128'hA5C3_1234_BEEF_0000_FFFE_8001_4321_CAFE, pmask: 8'h02,
              exp: 128'hC3A5_3412_EFBE_0000_FEFF_0180_2143_FECA};
    vt[3] = '{wc: 2'd3, hws: 128'hDEAD_BEEF_0123_4567_89AB_CDEF_7FFE_5A5A, pmask: 8'hFF,
              exp: 128'hADDE_EFBE_2301_6745_AB89_EFCD_FE7F_5A5A};

    rstn  = 1'b0;
    dina  = '0;
    dinb  = '0;
    wcode = 2'd3;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_valid",   128'(u_if.frameValid), 128'd0);
    chk("rst_frame",   u_if.frame,            128'd0);
    chk("rst_synced",  128'(synced),          128'd0);
    chk("rst_lost",    128'(lost),            128'd0);
    chk("rst_valid_s", 128'(u_if_s.frameValid), 128'd0);
    rstn = 1'b1;

    // Sync expiry on the SYNC_BITS=4 instance (8-bit bus)
    ready = 1'b1;
    set_width(2'd3);
    q.delete();
    send_sync();
    for (int k = 1; k <= 16; k++) begin
      pass(1);
      if (k == 1)  chk("syncexp_edge1",  128'(synced_s), 128'd1);
      if (k == 15) chk("syncexp_edge15", 128'(synced_s), 128'd1);
      if (k == 16) chk("syncexp_edge16", 128'(synced_s), 128'd0);
    end
    send_frame(128'h1001_1002_1003_1004_1005_1006_1007_1008, 8'h00);
    pass(3);
    chk("syncexp_nopush_s", 128'(u_if_s.frameValid), 128'd0);
    chk("syncexp_nolost_s", 128'(lost_s),           128'd0);
    chk("syncexp_main_cnt", 128'(q.size()),         128'd1);
    chk("syncexp_main_frm", (q.size() > 0) ? q[0] : '0,
        128'h0110_0210_0310_0410_0510_0610_0710_0810);

    // Table-driven single-frame vectors
    for (int v = 0; v < 4; v++) begin
      set_width(vt[v].wc);
      q.delete();
      send_sync();
      send_frame(vt[v].hws, vt[v].pmask);
      pass(3);
      chk($sformatf("vec%0d_count", v),  128'(q.size()), 128'd1);
      chk($sformatf("vec%0d_frame", v),  (q.size() > 0) ? q[0] : '0, vt[v].exp);
      chk($sformatf("vec%0d_synced", v), 128'(synced), 128'd1);
      chk($sformatf("vec%0d_lost", v),   128'(lost),   128'd0);
    end

    // Overflow: six frames into a 4-deep FIFO with the consumer stalled
    ready = 1'b0;
    set_width(2'd3);
    q.delete();
    send_sync();
    pass(1);
    for (int f = 0; f < 6; f++) send_frame_a(f);
    pass(3);
    chk("ovf_valid", 128'(u_if.frameValid), 128'd1);
    chk("ovf_lost",  128'(lost),            128'd2);
    chk("ovf_head",  u_if.frame,            mkframe(0));

    // Full FIFO, pop on the completion edge: push accepted, no drop
    send_frame_a(6);
    ready = 1'b1;
    pass(1);
    ready = 1'b0;
    pass(2);
    chk("fullpop_lost",  128'(lost),            128'd2);
    chk("fullpop_valid", 128'(u_if.frameValid), 128'd1);
    ready = 1'b1;
    pass(6);
    ready = 1'b0;
    chk("drain_count", 128'(q.size()), 128'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_frame%0d", i), (q.size() > i) ? q[i] : '0,
          mkframe((i == 4) ? 6 : i));
    end
    chk("drain_empty", 128'(u_if.frameValid), 128'd0);

    // Re-sync mid-frame, then width change mid-frame
    ready = 1'b1;
    set_width(2'd1);
    q.delete();
    send_sync();
    send_hw(16'h1111);
    send_hw(16'h2222);
    send_hw(16'h3333);
    send_sync();
    send_hw(16'h4444);
    send_hw(16'h5555);
    send_hw(16'h6666);
    wcode = 2'd2;
    beat(8'h00, 8'h00);
    chk("wchg_synced", 128'(synced), 128'd0);
    beat(8'h00, 8'h00);
    beat(8'h00, 8'h00);
    chk("wchg_nopush", 128'(q.size()), 128'd0);
    send_sync();
    send_frame(128'h0A0B_1C1D_2E2F_3031_4243_5455_6667_7879, 8'h00);
    pass(3);
    chk("realign_count",  128'(q.size()), 128'd1);
    chk("realign_frame",  (q.size() > 0) ? q[0] : '0,
        128'h0B0A_1D1C_2F2E_3130_4342_5554_6766_7978);
    chk("realign_synced", 128'(synced), 128'd1);

    // Asynchronous reset mid-frame with a frame held and drops counted
    ready = 1'b0;
    send_frame(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 8'h00);
    pass(2);
    send_hw(16'h1234);
    send_hw(16'h5678);
    send_hw(16'h9ABC);
    chk("prerst_valid", 128'(u_if.frameValid), 128'd1);
    chk("prerst_lost",  128'(lost),            128'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid",  128'(u_if.frameValid), 128'd0);
    chk("arst_frame",  u_if.frame,            128'd0);
    chk("arst_synced", 128'(synced),          128'd0);
    chk("arst_lost",   128'(lost),            128'd0);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    beat(8'h00, 8'h00);
    beat(8'h00, 8'h00);
    chk("postrst_valid", 128'(u_if.frameValid), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
